// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, ALU/immediate encodings, FSM states and shared datapath helpers
// for the multicycle RV32I-subset core.
package riscv_pkg;
   localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_RTYPE = 7'b0110011,
                          OP_ITYPE = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
   localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                          ALU_OR = 3'b011, ALU_SLT = 3'b101;
   typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} immsrc_t;
   typedef enum logic [3:0] {FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
                             EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP} state_t;
   function automatic logic [31:0] immext(input logic [31:0] i, input immsrc_t src);
      return src == IMM_I ? {{20{i[31]}}, i[31:20]} :
             src == IMM_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
             src == IMM_B ? {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0} :
                            {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
   endfunction
   function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl);
      return ctl == ALU_SUB ? a - b :
             ctl == ALU_AND ? a & b :
             ctl == ALU_OR  ? a | b :
             ctl == ALU_SLT ? {31'b0, $signed(a) < $signed(b)} : a + b;
   endfunction
endpackage

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: instruction sequencing FSM and decode of op/funct3/funct7b5
// into register enables and datapath mux selects.
module riscv_mc_ctrl
   import riscv_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       adr_sel,
   output logic       instr_en,
   output logic       ab_en,
   output logic       aluout_en,
   output logic       aluout_pc,
   output logic       data_en,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       reg_we,
   output logic       wd_data,
   output logic       a_old,
   output logic       b_imm,
   output immsrc_t    immsrc,
   output logic [2:0] alu_ctl,
   output logic       retire,
   output logic       halted
);
   state_t state, next, dec_next;
   logic [2:0] alu_dec;
   assign alu_dec = funct3 == 3'b111 ? ALU_AND : funct3 == 3'b110 ? ALU_OR :
                    funct3 == 3'b010 ? ALU_SLT : ALU_ADD;
   assign dec_next = (op == OP_LW || op == OP_SW) ? MEMADR :
                     op == OP_RTYPE ? EXECR :
                     op == OP_ITYPE ? EXECI :
                     (op == OP_BRANCH && funct3[2:1] == 2'b00) ? BRANCH :
                     op == OP_JAL ? JAL : TRAP;
   assign halted = state == TRAP;
   always_ff @(posedge clk) state <= reset ? FETCH : next;
   always_comb begin
      next = state;
      {mem_req, mem_we, adr_sel, instr_en, ab_en, aluout_en, aluout_pc, data_en} = '0;
      {pc_en, reg_we, wd_data, a_old, b_imm, retire} = '0;
      pc_src = 2'd0;
      immsrc = IMM_I;
      alu_ctl = ALU_ADD;
      case (state)
         FETCH: begin
            mem_req = 1'b1;
            instr_en = mem_ready;
            pc_en = mem_ready;
            next = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            {ab_en, aluout_en, a_old, b_imm} = '1;
            immsrc = IMM_B;
            next = dec_next;
         end
         MEMADR: begin
            {aluout_en, b_imm} = '1;
            immsrc = op == OP_SW ? IMM_S : IMM_I;
            next = op == OP_SW ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            {mem_req, adr_sel} = '1;
            data_en = mem_ready;
            next = mem_ready ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            {reg_we, wd_data, retire} = '1;
            next = FETCH;
         end
         MEMWRITE: begin
            {mem_req, mem_we, adr_sel} = '1;
            retire = mem_ready;
            next = mem_ready ? FETCH : MEMWRITE;
         end
         EXECR: begin
            aluout_en = 1'b1;
            alu_ctl = (funct3 == 3'b000 && funct7b5) ? ALU_SUB : alu_dec;
            next = ALUWB;
         end
         EXECI: begin
            {aluout_en, b_imm} = '1;
            alu_ctl = alu_dec;
            next = ALUWB;
         end
         ALUWB: begin
            {reg_we, retire} = '1;
            next = FETCH;
         end
         BRANCH: begin
            alu_ctl = ALU_SUB;
            pc_en = zero ^ funct3[0];
            pc_src = 2'd1;
            retire = 1'b1;
            next = FETCH;
         end
         JAL: begin
            {a_old, b_imm, pc_en, aluout_en, aluout_pc} = '1;
            immsrc = IMM_J;
            pc_src = 2'd2;
            next = ALUWB;
         end
         TRAP: next = TRAP;
         default: next = FETCH;
      endcase
      // a reset cycle must not commit anything from the aborted instruction
      if (reset) {mem_req, mem_we, retire, reg_we, pc_en, instr_en, data_en} = '0;
   end
endmodule

// File: rtl/riscv_multicycle.sv
// riscv_multicycle: multicycle RV32I-subset core sharing one memory port
// between instruction fetch and data access.
module riscv_multicycle
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc,
   output logic        retire,
   output logic        halted
);
   logic [31:0] oldpc, instr, data, a, b, aluout, rd1, rd2, srca, srcb, aluresult, imm, pc_next;
   logic [31:0] rf [32];
   logic adr_sel, instr_en, ab_en, aluout_en, aluout_pc, data_en, pc_en, reg_we, wd_data, a_old, b_imm;
   logic [1:0] pc_src;
   logic [2:0] alu_ctl;
   immsrc_t immsrc;
   riscv_mc_ctrl u_ctrl (
      .clk(clk), .reset(reset), .op(instr[6:0]), .funct3(instr[14:12]), .funct7b5(instr[30]),
      .zero(aluresult == 32'h0), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .adr_sel(adr_sel), .instr_en(instr_en), .ab_en(ab_en), .aluout_en(aluout_en),
      .aluout_pc(aluout_pc), .data_en(data_en), .pc_en(pc_en), .pc_src(pc_src), .reg_we(reg_we),
      .wd_data(wd_data), .a_old(a_old), .b_imm(b_imm), .immsrc(immsrc), .alu_ctl(alu_ctl),
      .retire(retire), .halted(halted)
   );
   assign imm = immext(instr, immsrc);
   assign rd1 = instr[19:15] == 5'd0 ? 32'h0 : rf[instr[19:15]];
   assign rd2 = instr[24:20] == 5'd0 ? 32'h0 : rf[instr[24:20]];
   assign srca = a_old ? oldpc : a;
   assign srcb = b_imm ? imm : b;
   assign aluresult = alu(srca, srcb, alu_ctl);
   assign pc_next = pc_src == 2'd2 ? aluresult : pc_src == 2'd1 ? aluout : pc + 32'd4;
   assign mem_adr = adr_sel ? aluout : pc;
   assign mem_wdata = b;
   always_ff @(posedge clk) begin
      if (reset) pc <= RESET_PC;
      else if (pc_en) pc <= pc_next;
      if (instr_en) begin
         instr <= mem_rdata;
         oldpc <= pc;
      end
      if (ab_en) begin
         a <= rd1;
         b <= rd2;
      end
      // in JAL the already-incremented pc is the link value oldpc+4
      if (aluout_en) aluout <= aluout_pc ? pc : aluresult;
      if (data_en) data <= mem_rdata;
      if (reg_we && instr[11:7] != 5'd0) rf[instr[11:7]] <= wd_data ? data : aluout;
   end
endmodule

// File: tb/tb_riscv_multicycle.sv
// tb_riscv_multicycle: directed programs against a wait-state memory model; expected
// bus transactions are queued by the stimulus and popped by a bus monitor.
`timescale 1ns/1ps
module tb_riscv_multicycle;
   typedef struct {logic we; logic [31:0] adr; logic [31:0] wd;} xact_t;
   logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
   logic mem_req, mem_we, retire, halted;
   logic [31:0] mem_adr, mem_wdata, pc, mem_rdata = 32'h0;
   logic [31:0] mem [0:255];
   xact_t exp_q[$];
   xact_t e;
   int checks = 0, failures = 0, wait_n = 0, ret_cnt = 0, cnt = 0;
   logic p_wait = 1'b0, p_we = 1'b0;
   logic [31:0] p_adr = 32'h0, p_wd = 32'h0;
   logic [31:0] alu_prog [10];
   logic [31:0] alu_res [8];

   always #5 clk = ~clk;

   riscv_multicycle #(.RESET_PC(32'h100)) dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
      .retire(retire), .halted(halted)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
      logic [31:0] v;
      v = imm;
      return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
   endfunction
   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
      logic [31:0] v;
      v = imm;
      return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
      logic [31:0] v;
      v = imm;
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_j(input int imm, input int rd);
      logic [31:0] v;
      v = imm;
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
   endfunction
   function automatic logic [31:0] enc_r(input int f7b5, input int rs2, input int rs1, input int f3, input int rd);
      return {1'b0, 1'(f7b5), 5'b0, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0000_007F;
   endtask
   task automatic put(input logic [31:0] a, input logic [31:0] w);
      mem[a[9:2]] = w;
   endtask
   task automatic exp_acc(input logic we, input logic [31:0] a, input logic [31:0] d);
      xact_t x;
      x.we = we;
      x.adr = a;
      x.wd = d;
      exp_q.push_back(x);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      ret_cnt = 0;
   endtask
   task automatic lat(input int exp, input string name);
      int n = 0;
      for (int i = 1; i <= 60 && n == 0; i++) begin
         @(negedge clk);
         if (retire) n = i;
      end
      check(name, n, exp);
   endtask
   task automatic run_halt(input int exp_ret, input string name);
      for (int i = 0; i < 400 && !halted; i++) @(negedge clk);
      check({name, "_halted"}, 32'(halted), 32'd1);
      repeat (3) @(negedge clk);
      check({name, "_no_req_after_halt"}, 32'(mem_req), 32'd0);
      check({name, "_queue_drained"}, exp_q.size(), 32'd0);
      check({name, "_retires"}, ret_cnt, exp_ret);
      @(posedge clk);
      #1;
   endtask

   // memory responder: wait_n cycles of mem_ready=0 per request, then one ready cycle
   always @(posedge clk) begin
      #2;
      if (mem_req) begin
         if (cnt >= wait_n) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_adr[9:2]];
            if (mem_we) mem[mem_adr[9:2]] = mem_wdata;
            cnt = 0;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = 32'h0;
            cnt++;
         end
      end else begin
         mem_ready = 1'b0;
         cnt = 0;
      end
   end

   always @(negedge clk) begin
      if (retire) ret_cnt++;
      if (p_wait && mem_req && !reset) begin
         check("hold_adr", mem_adr, p_adr);
         check("hold_we", 32'(mem_we), 32'(p_we));
         if (p_we) check("hold_wdata", mem_wdata, p_wd);
      end
      if (mem_req && mem_ready && !reset) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_access actual_adr=%h required=no_access", mem_adr);
         end else begin
            e = exp_q.pop_front();
            check("acc_we", 32'(mem_we), 32'(e.we));
            check("acc_adr", mem_adr, e.adr);
            if (e.we) check("acc_wdata", mem_wdata, e.wd);
         end
      end
      p_wait = mem_req && !mem_ready && !reset;
      p_we = mem_we;
      p_adr = mem_adr;
      p_wd = mem_wdata;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      @(posedge clk);
      #1;
      // reset values and the first fetch
      clear_mem();
      put(32'h100, enc_i(5, 0, 0, 1, 7'h13));
      reset = 1'b1;
      @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_retire", 32'(retire), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      ret_cnt = 0;
      exp_acc(1'b0, 32'h100, 32'h0);
      exp_acc(1'b0, 32'h104, 32'h0);
      @(negedge clk);
      check("t1_pc_reset", pc, 32'h100);
      check("t1_first_adr", mem_adr, 32'h100);
      check("t1_first_we", 32'(mem_we), 32'd0);
      check("t1_halted_reset", 32'(halted), 32'd0);
      @(negedge clk);
      check("t1_pc_after_fetch", pc, 32'h104);
      run_halt(1, "t1");

      // addi then sw, store must be on the bus in cycle 8
      clear_mem();
      put(32'h100, enc_i(7, 0, 0, 2, 7'h13));
      put(32'h104, enc_s(8, 2, 0, 2));
      do_reset();
      exp_acc(1'b0, 32'h100, 32'h0);
      exp_acc(1'b0, 32'h104, 32'h0);
      exp_acc(1'b1, 32'h008, 32'd7);
      exp_acc(1'b0, 32'h108, 32'h0);
      repeat (7) @(posedge clk);
      @(negedge clk);
      check("t2_c8_we", 32'(mem_we), 32'd1);
      check("t2_c8_adr", mem_adr, 32'h8);
      check("t2_c8_wdata", mem_wdata, 32'd7);
      run_halt(2, "t2");

      // lw with three wait states on fetch and data read
      wait_n = 3;
      clear_mem();
      put(32'h100, enc_i(32'h40, 0, 2, 3, 7'h03));
      put(32'h104, enc_s(32'h44, 3, 0, 2));
      put(32'h040, 32'hDEAD_BEEF);
      do_reset();
      exp_acc(1'b0, 32'h100, 32'h0);
      exp_acc(1'b0, 32'h040, 32'h0);
      exp_acc(1'b0, 32'h104, 32'h0);
      exp_acc(1'b1, 32'h044, 32'hDEAD_BEEF);
      exp_acc(1'b0, 32'h108, 32'h0);
      lat(11, "t3_lw_latency");
      run_halt(2, "t3");
      check("t3_mem_word", mem[32'h44 >> 2], 32'hDEAD_BEEF);
      wait_n = 0;

      // beq taken, bne not taken, bne taken, beq not taken
      clear_mem();
      put(32'h100, enc_b(16, 0, 0, 0));
      put(32'h110, enc_b(16, 0, 0, 1));
      put(32'h114, enc_i(1, 0, 0, 5, 7'h13));
      put(32'h118, enc_b(8, 0, 5, 1));
      put(32'h120, enc_b(8, 0, 5, 0));
      do_reset();
      exp_acc(1'b0, 32'h100, 32'h0);
      exp_acc(1'b0, 32'h110, 32'h0);
      exp_acc(1'b0, 32'h114, 32'h0);
      exp_acc(1'b0, 32'h118, 32'h0);
      exp_acc(1'b0, 32'h120, 32'h0);
      exp_acc(1'b0, 32'h124, 32'h0);
      lat(3, "t4_beq_latency");
      run_halt(5, "t4");

      // jal forward with x0, jal backward linking x1, stores expose x1 and x0
      clear_mem();
      put(32'h100, enc_j(32'h40, 0));
      put(32'h140, enc_j(-8, 1));
      put(32'h138, enc_s(32'h10, 1, 0, 2));
      put(32'h13C, enc_j(32'h20, 0));
      put(32'h15C, enc_s(32'h14, 0, 0, 2));
      do_reset();
      exp_acc(1'b0, 32'h100, 32'h0);
      exp_acc(1'b0, 32'h140, 32'h0);
      exp_acc(1'b0, 32'h138, 32'h0);
      exp_acc(1'b1, 32'h010, 32'h144);
      exp_acc(1'b0, 32'h13C, 32'h0);
      exp_acc(1'b0, 32'h15C, 32'h0);
      exp_acc(1'b1, 32'h014, 32'h0);
      exp_acc(1'b0, 32'h160, 32'h0);
      lat(4, "t5_jal_latency");
      run_halt(5, "t5");

      // R-type and I-type ALU operations, results stored to 0x80..0x9C
      alu_prog = '{enc_i(5, 0, 0, 1, 7'h13), enc_i(-3, 0, 0, 2, 7'h13), enc_r(0, 2, 1, 0, 3),
                   enc_r(1, 2, 1, 0, 4), enc_r(0, 2, 1, 7, 5), enc_r(0, 2, 1, 6, 6),
                   enc_r(0, 1, 2, 2, 7), enc_i(-1, 1, 2, 8, 7'h13), enc_i(15, 2, 7, 9, 7'h13),
                   enc_i(32'h30, 1, 6, 10, 7'h13)};
      alu_res = '{32'd2, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd1, 32'd0, 32'hD, 32'h35};
      clear_mem();
      for (int i = 0; i < 10; i++) put(32'h100 + 32'(4 * i), alu_prog[i]);
      for (int k = 0; k < 8; k++) put(32'h128 + 32'(4 * k), enc_s(32'h80 + 4 * k, 3 + k, 0, 2));
      do_reset();
      for (int i = 0; i < 10; i++) exp_acc(1'b0, 32'h100 + 32'(4 * i), 32'h0);
      for (int k = 0; k < 8; k++) begin
         exp_acc(1'b0, 32'h128 + 32'(4 * k), 32'h0);
         exp_acc(1'b1, 32'h80 + 32'(4 * k), alu_res[k]);
      end
      exp_acc(1'b0, 32'h148, 32'h0);
      lat(4, "t6_addi_latency");
      run_halt(18, "t6");

      // illegal opcode: halted rises the cycle after DECODE
      clear_mem();
      do_reset();
      exp_acc(1'b0, 32'h100, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("t7_decode_not_halted", 32'(halted), 32'd0);
      @(negedge clk);
      check("t7_trap_halted", 32'(halted), 32'd1);
      run_halt(0, "t7");

      // unsupported branch funct3 traps as well
      clear_mem();
      put(32'h100, enc_b(8, 0, 0, 4));
      do_reset();
      exp_acc(1'b0, 32'h100, 32'h0);
      run_halt(0, "t7b");

      // reset landing on the MEMWRITE cycle suppresses the store
      clear_mem();
      put(32'h100, enc_i(9, 0, 0, 2, 7'h13));
      put(32'h104, enc_s(32'h20, 2, 0, 2));
      put(32'h020, 32'h55);
      do_reset();
      exp_acc(1'b0, 32'h100, 32'h0);
      exp_acc(1'b0, 32'h104, 32'h0);
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("t8_reset_req", 32'(mem_req), 32'd0);
      check("t8_reset_we", 32'(mem_we), 32'd0);
      check("t8_reset_retire", 32'(retire), 32'd0);
      check("t8_retires_before", ret_cnt, 32'd1);
      @(posedge clk);
      #1 reset = 1'b0;
      ret_cnt = 0;
      check("t8_no_write", mem[32'h20 >> 2], 32'h55);
      exp_acc(1'b0, 32'h100, 32'h0);
      exp_acc(1'b0, 32'h104, 32'h0);
      exp_acc(1'b1, 32'h020, 32'd9);
      exp_acc(1'b0, 32'h108, 32'h0);
      @(negedge clk);
      check("t8_restart_adr", mem_adr, 32'h100);
      run_halt(2, "t8");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
